// File: rtl/prim_gate_pipe.sv
// prim_gate_pipe
//   Applies one runtime-selected bitwise gate function to NIN operands of
//   WIDTH bits each. The result then passes through a STAGES-deep
//   valid/ready register pipeline. A transaction never waits behind an empty
//   stage, and results leave in the order they were accepted.
//
// Optional feature: define PRIM_GATE_PIPE_CNT_EN to add out_count, a 16-bit
//   count of consumed results that saturates at 0xFFFF.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   in_valid   in   input transaction present
//   in_ready   out  pipeline can accept this cycle
//   in_op      in   gate select: 0 and, 1 or, 2 xor, 3 xnor, 4 nand, 5 nor,
//                   6 buf, 7 not
//   in_data    in   operands; operand k = in_data[k*WIDTH +: WIDTH]
//   out_valid  out  result present in the last stage
//   out_ready  in   consumer accepts
//   out_data   out  result
//   out_op     out  opcode that produced out_data
//   occupancy  out  number of valid stages
//   out_count  out  consumed-result count (PRIM_GATE_PIPE_CNT_EN only)
module prim_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NIN    = 3,
  parameter int STAGES = 2,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_op,
  output logic [OCC_W-1:0]     occupancy
`ifdef PRIM_GATE_PIPE_CNT_EN
  ,
  output logic [15:0]          out_count
`endif
);

  // Gate function
  logic [WIDTH-1:0] and_red, or_red, xor_red, fn_res;

  always_comb begin
    and_red = in_data[WIDTH-1:0];
    or_red  = in_data[WIDTH-1:0];
    xor_red = in_data[WIDTH-1:0];
    for (int k = 1; k < NIN; k++) begin
      and_red = and_red & in_data[k*WIDTH +: WIDTH];
      or_red  = or_red  | in_data[k*WIDTH +: WIDTH];
      xor_red = xor_red ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    fn_res = '0;
    case (in_op)
      3'd0: fn_res = and_red;
      3'd1: fn_res = or_red;
      3'd2: fn_res = xor_red;
      3'd3: fn_res = ~xor_red;
      3'd4: fn_res = ~and_red;
      3'd5: fn_res = ~or_red;
      3'd6: fn_res = in_data[WIDTH-1:0];
      3'd7: fn_res = ~in_data[WIDTH-1:0];
      default: fn_res = '0;
    endcase
  end

  // Pipeline stages
  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [2:0]        op_q   [STAGES];
  logic [2:0]        op_d   [STAGES];
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic              accept, consume;

  // A stage advances when the stage after it is empty or also advancing.
  // Computing this from the output end backwards lets bubbles collapse in a
  // single cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = valid_q[STAGES-1] & out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = valid_q[i] & (~valid_q[i+1] | adv[i+1]);
    end
  end

  // in_ready depends only on the valid bits and out_ready, never on in_valid.
  assign in_ready = ~valid_q[0] | adv[0];
  assign accept   = in_valid & in_ready;
  assign consume  = adv[STAGES-1];

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    for (int i = STAGES - 1; i >= 1; i--) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        op_d[i]    = op_q[i-1];
        data_d[i]  = data_q[i-1];
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (accept) begin
      valid_d[0] = 1'b1;
      op_d[0]    = in_op;
      data_d[0]  = fn_res;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        op_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  // Occupancy counter
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({accept, consume})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];

`ifdef PRIM_GATE_PIPE_CNT_EN
  // Saturating count of consumed results
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (consume && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_prim_gate_pipe.sv
// Directed testbench for prim_gate_pipe. It uses a WIDTH=8, NIN=3, STAGES=2
// instance and a WIDTH=8, NIN=1, STAGES=1 instance.
module tb_prim_gate_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  // Instance A: WIDTH=8, NIN=3, STAGES=2
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op, out_op;
  logic [23:0] in_data;
  logic [7:0]  out_data;
  logic [1:0]  occupancy;

  // Instance B: WIDTH=8, NIN=1, STAGES=1
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [2:0]  u_in_op, u_out_op;
  logic [7:0]  u_in_data, u_out_data;
  logic [0:0]  u_occupancy;

`ifdef PRIM_GATE_PIPE_CNT_EN
  logic [15:0] out_count, u_out_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prim_gate_pipe #(.WIDTH(8), .NIN(3), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .occupancy(occupancy)
`ifdef PRIM_GATE_PIPE_CNT_EN
    , .out_count(out_count)
`endif
  );

  prim_gate_pipe #(.WIDTH(8), .NIN(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .in_op(u_in_op), .in_data(u_in_data),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
    .out_op(u_out_op), .occupancy(u_occupancy)
`ifdef PRIM_GATE_PIPE_CNT_EN
    , .out_count(u_out_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  bb_op  [4];
  logic [23:0] bb_dat [4];
  logic [7:0]  bb_exp [4];

  initial begin
    bb_op[0] = 3'd3; bb_dat[0] = {8'h00, 8'h0F, 8'hAA}; bb_exp[0] = 8'h5A;
    bb_op[1] = 3'd5; bb_dat[1] = {8'h04, 8'h02, 8'h01}; bb_exp[1] = 8'hF8;
    bb_op[2] = 3'd7; bb_dat[2] = {8'hFF, 8'hFF, 8'h3C}; bb_exp[2] = 8'hC3;
    bb_op[3] = 3'd6; bb_dat[3] = {8'h66, 8'h55, 8'h81}; bb_exp[3] = 8'h81;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = 3'd0; in_data = '0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_in_op = 3'd0; u_in_data = '0; u_out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    #11 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single AND transaction: result visible after the second edge
    in_valid = 1'b1; in_op = 3'd0; in_data = {8'hFF, 8'h3C, 8'hF0};
    tick();
    in_valid = 1'b0;
    check("and_stage0_out_valid", 32'(out_valid), 32'd0);
    check("and_stage0_occ", 32'(occupancy), 32'd1);
    tick();
    check("and_out_valid", 32'(out_valid), 32'd1);
    check("and_out_data", 32'(out_data), 32'h30);
    check("and_out_op", 32'(out_op), 32'd0);
    tick();
    check("and_drained_valid", 32'(out_valid), 32'd0);
    check("and_drained_occ", 32'(occupancy), 32'd0);

    // Back-to-back transactions, one result per cycle
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_op = bb_op[j]; in_data = bb_dat[j];
      tick();
      if (j >= 1) begin
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data", 32'(out_data), 32'(bb_exp[j-1]));
        check("b2b_op", 32'(out_op), 32'(bb_op[j-1]));
      end
    end
    in_valid = 1'b0;
    tick();
    check("b2b_last_data", 32'(out_data), 32'(bb_exp[3]));
    check("b2b_last_op", 32'(out_op), 32'd6);
    tick();
    check("b2b_drained_occ", 32'(occupancy), 32'd0);

    // Back-pressure: two accepted, third held
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd1; in_data = {8'h04, 8'h02, 8'h01};
    tick();
    in_data = {8'h00, 8'h00, 8'h10};
    tick();
    check("full_occ", 32'(occupancy), 32'd2);
    in_data = {8'h00, 8'h00, 8'h20};
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_hold_occ", 32'(occupancy), 32'd2);
    check("full_hold_valid", 32'(out_valid), 32'd1);
    check("full_hold_data", 32'(out_data), 32'h07);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("drain1_data", 32'(out_data), 32'h10);
    check("drain1_occ", 32'(occupancy), 32'd2);
    tick();
    check("drain2_data", 32'(out_data), 32'h20);
    check("drain2_occ", 32'(occupancy), 32'd1);
    tick();
    check("drain3_valid", 32'(out_valid), 32'd0);
    check("drain3_occ", 32'(occupancy), 32'd0);

    // Full pipe, accept and consume every cycle
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_op = 3'd6; in_data = {8'h00, 8'h00, 8'(8'h40 + k)};
      tick();
      if (k >= 1) begin
        check("stream_occ", 32'(occupancy), 32'd2);
        check("stream_data", 32'(out_data), 32'(8'h40 + k - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_last_data", 32'(out_data), 32'h45);
    check("stream_last_occ", 32'(occupancy), 32'd1);
    tick();
    check("stream_empty_occ", 32'(occupancy), 32'd0);

    // Asynchronous reset with two transactions in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_data = {8'hFF, 8'hFF, 8'h11};
    tick();
    in_data = {8'hFF, 8'hFF, 8'h22};
    tick();
    in_valid = 1'b0;
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst2_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = 3'd2; in_data = {8'h01, 8'h0F, 8'hFF};
    tick();
    in_valid = 1'b0;
    tick();
    check("xor_valid", 32'(out_valid), 32'd1);
    check("xor_data", 32'(out_data), 32'hF1);
    check("xor_op", 32'(out_op), 32'd2);
    tick();
    check("xor_drained", 32'(out_valid), 32'd0);

    // NIN=1, STAGES=1 instance
    u_in_valid = 1'b1; u_in_op = 3'd4; u_in_data = 8'h5A;
    tick();
    u_in_valid = 1'b0;
    check("n1_valid", 32'(u_out_valid), 32'd1);
    check("n1_data", 32'(u_out_data), 32'hA5);
    check("n1_op", 32'(u_out_op), 32'd4);
    check("n1_occ", 32'(u_occupancy), 32'd1);
    tick();
    check("n1_drained", 32'(u_out_valid), 32'd0);
`ifdef PRIM_GATE_PIPE_CNT_EN
    check("n1_out_count", 32'(u_out_count), 32'd1);
    check("a_out_count", 32'(out_count), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
